mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between the instruction cache (read-only) and the data cache (read/write, byte-serial block fill and write-back).
- Sequences one byte per transaction and returns a one-cycle done pulse to the granted requester.
- Grant is locked for a whole burst, so a cache block fill or write-back is never interleaved with the other requester.
- Sits between both caches and the top-level RAM/IO port.

Parameters:
ADDR_W, 32, width of byte address on all ports
DATA_W, 8, RAM data width (one byte)
IO_BASE_HI, 2'b11, value of addr[17:16] identifying the memory-mapped IO window

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rdy  input  1  global enable; low freezes arbitration
ic_read_i  input  1  I-cache byte read request
ic_addr_i  input  ADDR_W  I-cache byte address
ic_data_o  output  DATA_W  read byte to I-cache
ic_done_o  output  1  one-cycle pulse: I-cache byte complete
dc_read_i  input  1  D-cache byte read request
dc_write_i  input  1  D-cache byte write request
dc_addr_i  input  ADDR_W  D-cache byte address
dc_data_i  input  DATA_W  D-cache write byte
dc_data_o  output  DATA_W  read byte to D-cache
dc_done_o  output  1  one-cycle pulse: D-cache byte complete
mem_din  input  DATA_W  RAM read data, valid one cycle after address
mem_dout  output  DATA_W  RAM write data
mem_a  output  ADDR_W  RAM address
mem_wr  output  1  1 = write, 0 = read
io_buffer_full  input  1  IO output FIFO full

Behaviour:
- Reset (async, rst_n low): state=IDLE, owner=NONE, last_owner=IC, mem_wr=0, mem_a=0, mem_dout=0, ic_done_o=0, dc_done_o=0, ic_data_o=0, dc_data_o=0. mem_wr drops immediately, even mid-write.
- States:
  - IDLE: no access in flight.
  - RD_WAIT: address issued, waiting one cycle for mem_din.
  - WR_DONE: write issued, completion pulse next.
- Requests are level-sensitive. Each byte is a separate transaction. The requester holds its request and updates the address after each done pulse.
- Arbitration, in IDLE with rdy=1:
  - If owner≠NONE and the owner still requests, serve the owner (burst lock).
  - Otherwise, if both request, grant the one that is not last_owner (round-robin); if only one requests, grant it.
  - On grant: owner=last_owner=grantee.
- Issue cycle t (registered outputs):
  - Read: mem_a=addr, mem_wr=0, go to RD_WAIT.
  - Write: mem_a=addr, mem_dout=dc_data_i, mem_wr=1, go to WR_DONE.
  - If dc_read_i and dc_write_i are both high, write wins.
- RD_WAIT (cycle t+1): latch mem_din into the owner's data_o (held until the next read for that owner), pulse owner done, return to IDLE.
- WR_DONE (cycle t+1): mem_wr=0, pulse owner done, return to IDLE.
- Throughput: 2 cycles per byte. done is never asserted for more than 1 cycle, and never to both requesters in the same cycle.
- Burst release: owner is cleared in IDLE when the owner's request is low. A request drop mid-transaction still completes the byte; the done pulse may be ignored.
- rdy=0: no new issue; in-flight RD_WAIT/WR_DONE still complete; mem_wr forced 0 after any in-flight write.
- Address arithmetic: no modification; wrap is the requester's concern.
- mem_a holds its last value in IDLE (no spurious IO reads); mem_wr=0 in IDLE.

Optional Feature:
- Macro: MEM_ARBITER_IO_STALL_EN.
- Defined: a D-cache write with addr[17:16]==IO_BASE_HI and io_buffer_full=1 is not issued. The arbiter stays in IDLE holding the grant, with no done pulse, and re-evaluates every cycle. The I-cache is not granted while stalled, because the burst lock holds.
- Not defined: io_buffer_full is ignored and IO writes issue immediately.

Decomposition:
- Shared package/config header: state encoding (IDLE/RD_WAIT/WR_DONE), owner encoding (NONE/IC/DC), ADDR_W/DATA_W defaults, IO window constant.
- One natural sub-module: mem_arbiter_rr, a 2-way round-robin grant with burst lock (inputs: reqs, owner_active, last_owner; output: grant).
- FSM and datapath registers stay in the top.

Test Plan:
- I-cache alone reads 0x100..0x103 with RAM holding AA,BB,CC,DD → ic_done_o pulses at cycles 2,4,6,8; ic_data_o = AA,BB,CC,DD; mem_wr stays 0.
- D-cache writes 4 bytes 11,22,33,44 to 0x200 → mem_wr=1 at cycles 1,3,5,7 with matching mem_a/mem_dout; dc_done_o pulses the following cycles.
- Both request in the same cycle after reset (last_owner=IC) → DC granted; 4-byte DC burst completes uninterrupted, then IC is served; no interleaving on mem_a.
- rst_n asserted during WR_DONE → mem_wr and all done outputs are 0 immediately; after release, the first request issues cleanly from IDLE.
- rdy=0 while an IC request is pending → no mem_a change and no done; rdy=1 → issue on the next cycle.
- With MEM_ARBITER_IO_STALL_EN: DC writes to 0x30000 with io_buffer_full=1 for 5 cycles → no mem_wr, IC starved; full drops → write issued next cycle, dc_done_o one cycle later.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the I-cache / D-cache RAM port arbiter.
package mem_arbiter_pkg;
   localparam int          ADDR_W_DEF     = 32;
   localparam int          DATA_W_DEF     = 8;
   localparam logic [1:0]  IO_BASE_HI_DEF = 2'b11;

   localparam logic [1:0]  ST_IDLE    = 2'd0;
   localparam logic [1:0]  ST_RD_WAIT = 2'd1;
   localparam logic [1:0]  ST_WR_DONE = 2'd2;

   localparam logic [1:0]  OWN_NONE = 2'd0;
   localparam logic [1:0]  OWN_IC   = 2'd1;
   localparam logic [1:0]  OWN_DC   = 2'd2;
endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant with burst lock; i_reqs[0] is the I-cache, i_reqs[1] the D-cache.
module mem_arbiter_rr
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] i_reqs,
   input  logic [1:0] i_owner,
   input  logic [1:0] i_last_owner,
   output logic [1:0] o_grant
);
   always_comb begin
      o_grant = OWN_NONE;
      // A current owner that still requests keeps the port for the rest of its burst.
      if (i_owner == OWN_IC && i_reqs[0])
         o_grant = OWN_IC;
      else if (i_owner == OWN_DC && i_reqs[1])
         o_grant = OWN_DC;
      else if (&i_reqs)
         o_grant = (i_last_owner == OWN_IC) ? OWN_DC : OWN_IC;
      else if (i_reqs[0])
         o_grant = OWN_IC;
      else if (i_reqs[1])
         o_grant = OWN_DC;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between I-cache and D-cache, two cycles per byte.
// Optional: define MEM_ARBITER_IO_STALL_EN to hold D-cache IO writes while the IO FIFO is full.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int         ADDR_W     = ADDR_W_DEF,
   parameter int         DATA_W     = DATA_W_DEF,
   parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              ic_read_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   output logic [DATA_W-1:0] ic_data_o,
   output logic              ic_done_o,
   input  logic              dc_read_i,
   input  logic              dc_write_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [DATA_W-1:0] dc_data_i,
   output logic [DATA_W-1:0] dc_data_o,
   output logic              dc_done_o,
   input  logic [DATA_W-1:0] mem_din,
   output logic [DATA_W-1:0] mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);
   logic [1:0]        r_state;
   logic [1:0]        r_owner;
   logic [1:0]        r_last_owner;
   logic [ADDR_W-1:0] r_mem_a;
   logic [DATA_W-1:0] r_mem_dout;
   logic              r_mem_wr;
   logic [DATA_W-1:0] r_ic_data;
   logic [DATA_W-1:0] r_dc_data;
   logic              r_ic_done;
   logic              r_dc_done;

   logic [1:0]        w_reqs;
   logic [1:0]        w_grant;
   logic [ADDR_W-1:0] w_addr;
   logic              w_wr;
   logic              w_stall;

   assign w_reqs = {dc_read_i | dc_write_i, ic_read_i};

   mem_arbiter_rr u_rr (
      .i_reqs       (w_reqs),
      .i_owner      (r_owner),
      .i_last_owner (r_last_owner),
      .o_grant      (w_grant)
   );

   // Write takes priority when the D-cache raises read and write together.
   assign w_addr = (w_grant == OWN_DC) ? dc_addr_i : ic_addr_i;
   assign w_wr   = (w_grant == OWN_DC) && dc_write_i;

`ifdef MEM_ARBITER_IO_STALL_EN
   assign w_stall = w_wr && (dc_addr_i[17:16] == IO_BASE_HI) && io_buffer_full;
`else
   // IO writes never wait here; the FIFO-full flag is deliberately masked off.
   assign w_stall = 1'b0 & io_buffer_full;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWN_NONE;
         r_last_owner <= OWN_IC;
         r_mem_a      <= '0;
         r_mem_dout   <= '0;
         r_mem_wr     <= 1'b0;
         r_ic_data    <= '0;
         r_dc_data    <= '0;
         r_ic_done    <= 1'b0;
         r_dc_done    <= 1'b0;
      end else begin
         r_ic_done <= 1'b0;
         r_dc_done <= 1'b0;
         r_mem_wr  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rdy) begin
                  if (w_grant == OWN_NONE) begin
                     r_owner <= OWN_NONE;
                  end else begin
                     r_owner      <= w_grant;
                     r_last_owner <= w_grant;
                     // A stalled IO write keeps the grant and retries every cycle.
                     if (!w_stall) begin
                        r_mem_a <= w_addr;
                        if (w_wr) begin
                           r_mem_dout <= dc_data_i;
                           r_mem_wr   <= 1'b1;
                           r_state    <= ST_WR_DONE;
                        end else begin
                           r_state <= ST_RD_WAIT;
                        end
                     end
                  end
               end
            end
            ST_RD_WAIT: begin
               if (r_owner == OWN_DC) begin
                  r_dc_data <= mem_din;
                  r_dc_done <= 1'b1;
               end else begin
                  r_ic_data <= mem_din;
                  r_ic_done <= 1'b1;
               end
               r_state <= ST_IDLE;
            end
            ST_WR_DONE: begin
               r_dc_done <= (r_owner == OWN_DC);
               r_ic_done <= (r_owner == OWN_IC);
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_a     = r_mem_a;
   assign mem_dout  = r_mem_dout;
   assign mem_wr    = r_mem_wr;
   assign ic_data_o = r_ic_data;
   assign dc_data_o = r_dc_data;
   assign ic_done_o = r_ic_done;
   assign dc_done_o = r_dc_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; honours MEM_ARBITER_IO_STALL_EN when defined.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b1;
   logic        ic_read_i = 1'b0;
   logic [31:0] ic_addr_i = '0;
   logic [7:0]  ic_data_o;
   logic        ic_done_o;
   logic        dc_read_i = 1'b0;
   logic        dc_write_i = 1'b0;
   logic [31:0] dc_addr_i = '0;
   logic [7:0]  dc_data_i = '0;
   logic [7:0]  dc_data_o;
   logic        dc_done_o;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full = 1'b0;

   logic [7:0]  tb_ram [0:15];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign mem_din = tb_ram[mem_a[3:0]];

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .ic_read_i(ic_read_i), .ic_addr_i(ic_addr_i), .ic_data_o(ic_data_o), .ic_done_o(ic_done_o),
      .dc_read_i(dc_read_i), .dc_write_i(dc_write_i), .dc_addr_i(dc_addr_i), .dc_data_i(dc_data_i),
      .dc_data_o(dc_data_o), .dc_done_o(dc_done_o),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
      checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
      checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
      checks++; if ({ic_done_o, dc_done_o} !== 2'b00) begin errors++; $display("FAIL reset_done got=%b exp=00", {ic_done_o, dc_done_o}); end
      checks++; if ({ic_data_o, dc_data_o} !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {ic_data_o, dc_data_o}); end
   endtask

   task automatic test_ic_read();
      logic [7:0] exp_b [0:3];
      exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      ic_addr_i = 32'h100;
      ic_read_i = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++; if (ic_done_o !== (k % 2 == 0)) begin errors++; $display("FAIL ic_done k=%0d got=%b exp=%b", k, ic_done_o, (k % 2 == 0)); end
         checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL ic_mem_wr k=%0d got=%b exp=0", k, mem_wr); end
         if (k % 2 == 1) begin
            checks++; if (mem_a !== 32'h100 + 32'((k - 1) / 2)) begin errors++; $display("FAIL ic_mem_a k=%0d got=%h exp=%h", k, mem_a, 32'h100 + 32'((k - 1) / 2)); end
         end else begin
            checks++; if (ic_data_o !== exp_b[k/2-1]) begin errors++; $display("FAIL ic_data k=%0d got=%h exp=%h", k, ic_data_o, exp_b[k/2-1]); end
            ic_addr_i = ic_addr_i + 32'd1;
            if (k == 8) ic_read_i = 1'b0;
         end
      end
      step();
      checks++; if (ic_done_o !== 1'b0) begin errors++; $display("FAIL ic_idle_done got=%b exp=0", ic_done_o); end
      checks++; if (mem_a !== 32'h103) begin errors++; $display("FAIL ic_idle_mem_a got=%h exp=00000103", mem_a); end
   endtask

   task automatic test_dc_write();
      logic [7:0] wb [0:3];
      wb = '{8'h11, 8'h22, 8'h33, 8'h44};
      dc_addr_i  = 32'h200;
      dc_data_i  = wb[0];
      dc_write_i = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++; if (dc_done_o !== (k % 2 == 0)) begin errors++; $display("FAIL dc_done k=%0d got=%b exp=%b", k, dc_done_o, (k % 2 == 0)); end
         checks++; if (mem_wr !== (k % 2 == 1)) begin errors++; $display("FAIL dc_mem_wr k=%0d got=%b exp=%b", k, mem_wr, (k % 2 == 1)); end
         checks++; if (ic_done_o !== 1'b0) begin errors++; $display("FAIL dc_ic_done k=%0d got=%b exp=0", k, ic_done_o); end
         if (k % 2 == 1) begin
            checks++; if (mem_a !== 32'h200 + 32'((k - 1) / 2)) begin errors++; $display("FAIL dc_mem_a k=%0d got=%h exp=%h", k, mem_a, 32'h200 + 32'((k - 1) / 2)); end
            checks++; if (mem_dout !== wb[(k-1)/2]) begin errors++; $display("FAIL dc_mem_dout k=%0d got=%h exp=%h", k, mem_dout, wb[(k-1)/2]); end
         end else if (k == 8) begin
            dc_write_i = 1'b0;
         end else begin
            dc_addr_i = dc_addr_i + 32'd1;
            dc_data_i = wb[k/2];
         end
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0] db [0:3];
      db = '{8'h51, 8'h52, 8'h53, 8'h54};
      do_reset();
      ic_addr_i = 32'h104;
      dc_addr_i = 32'h108;
      ic_read_i = 1'b1;
      dc_read_i = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++; if (ic_done_o !== 1'b0) begin errors++; $display("FAIL rr_ic_done k=%0d got=%b exp=0", k, ic_done_o); end
         checks++; if (dc_done_o !== (k % 2 == 0)) begin errors++; $display("FAIL rr_dc_done k=%0d got=%b exp=%b", k, dc_done_o, (k % 2 == 0)); end
         if (k % 2 == 1) begin
            checks++; if (mem_a !== 32'h108 + 32'((k - 1) / 2)) begin errors++; $display("FAIL rr_mem_a k=%0d got=%h exp=%h", k, mem_a, 32'h108 + 32'((k - 1) / 2)); end
         end else begin
            checks++; if (dc_data_o !== db[k/2-1]) begin errors++; $display("FAIL rr_dc_data k=%0d got=%h exp=%h", k, dc_data_o, db[k/2-1]); end
            if (k == 8) dc_read_i = 1'b0;
            else dc_addr_i = dc_addr_i + 32'd1;
         end
      end
      step();
      checks++; if (mem_a !== 32'h104) begin errors++; $display("FAIL rr_ic_mem_a got=%h exp=00000104", mem_a); end
      step();
      checks++; if ({ic_done_o, dc_done_o} !== 2'b10) begin errors++; $display("FAIL rr_ic_done2 got=%b exp=10", {ic_done_o, dc_done_o}); end
      checks++; if (ic_data_o !== 8'hEE) begin errors++; $display("FAIL rr_ic_data got=%h exp=ee", ic_data_o); end
      ic_read_i = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_write();
      dc_addr_i  = 32'h300;
      dc_data_i  = 8'h5A;
      dc_write_i = 1'b1;
      step();
      checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rstw_issue got=%b exp=1", mem_wr); end
      rst_n = 1'b0;
      #1;
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rstw_mem_wr got=%b exp=0", mem_wr); end
      checks++; if ({ic_done_o, dc_done_o} !== 2'b00) begin errors++; $display("FAIL rstw_done got=%b exp=00", {ic_done_o, dc_done_o}); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300, 8'h5A}) begin errors++; $display("FAIL rstw_reissue got=%b/%h/%h exp=1/00000300/5a", mem_wr, mem_a, mem_dout); end
      dc_write_i = 1'b0;
      step();
      checks++; if ({dc_done_o, mem_wr} !== 2'b10) begin errors++; $display("FAIL rstw_done2 got=%b exp=10", {dc_done_o, mem_wr}); end
      step();
   endtask

   task automatic test_rdy();
      rdy       = 1'b0;
      ic_addr_i = 32'h101;
      ic_read_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++; if ({mem_a, ic_done_o} !== {32'h300, 1'b0}) begin errors++; $display("FAIL rdy_frozen k=%0d got=%h/%b exp=00000300/0", k, mem_a, ic_done_o); end
      end
      rdy = 1'b1;
      step();
      checks++; if ({mem_a, mem_wr} !== {32'h101, 1'b0}) begin errors++; $display("FAIL rdy_issue got=%h/%b exp=00000101/0", mem_a, mem_wr); end
      step();
      checks++; if ({ic_done_o, ic_data_o} !== {1'b1, 8'hBB}) begin errors++; $display("FAIL rdy_done got=%b/%h exp=1/bb", ic_done_o, ic_data_o); end
      ic_read_i = 1'b0;
      step();
      dc_addr_i  = 32'h204;
      dc_data_i  = 8'h99;
      dc_write_i = 1'b1;
      step();
      checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rdyw_issue got=%b exp=1", mem_wr); end
      rdy = 1'b0;
      step();
      checks++; if ({mem_wr, dc_done_o} !== 2'b01) begin errors++; $display("FAIL rdyw_complete got=%b exp=01", {mem_wr, dc_done_o}); end
      dc_write_i = 1'b0;
      step();
      checks++; if ({mem_wr, dc_done_o} !== 2'b00) begin errors++; $display("FAIL rdyw_idle got=%b exp=00", {mem_wr, dc_done_o}); end
      rdy = 1'b1;
   endtask

   task automatic test_io_write();
      do_reset();
      ic_addr_i      = 32'h100;
      ic_read_i      = 1'b1;
      dc_addr_i      = 32'h30000;
      dc_data_i      = 8'h77;
      dc_write_i     = 1'b1;
      io_buffer_full = 1'b1;
`ifdef MEM_ARBITER_IO_STALL_EN
      for (int k = 1; k <= 5; k++) begin
         step();
         checks++; if ({mem_wr, ic_done_o, dc_done_o, mem_a} !== {3'b000, 32'h0}) begin errors++; $display("FAIL io_stall k=%0d got=%b%b%b/%h exp=000/00000000", k, mem_wr, ic_done_o, dc_done_o, mem_a); end
      end
      io_buffer_full = 1'b0;
`endif
      step();
      checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h77}) begin errors++; $display("FAIL io_issue got=%b/%h/%h exp=1/00030000/77", mem_wr, mem_a, mem_dout); end
      dc_write_i = 1'b0;
      step();
      checks++; if ({dc_done_o, ic_done_o, mem_wr} !== 3'b100) begin errors++; $display("FAIL io_done got=%b exp=100", {dc_done_o, ic_done_o, mem_wr}); end
      step();
      checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL io_ic_next got=%h exp=00000100", mem_a); end
      ic_read_i      = 1'b0;
      io_buffer_full = 1'b0;
      step();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) tb_ram[i] = 8'h00;
      tb_ram[0]  = 8'hAA; tb_ram[1]  = 8'hBB; tb_ram[2]  = 8'hCC; tb_ram[3]  = 8'hDD;
      tb_ram[4]  = 8'hEE;
      tb_ram[8]  = 8'h51; tb_ram[9]  = 8'h52; tb_ram[10] = 8'h53; tb_ram[11] = 8'h54;
      test_reset();
      test_ic_read();
      test_dc_write();
      test_back_to_back();
      test_reset_mid_write();
      test_rdy();
      test_io_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
